fxywz_sweep_ctrl: RTL and testbench

//   Sequencer for the 4-input combinational function block fxywz (outputs s, t).
//   On start, drives every input vector m = {x,y,w,z} from 0 to 2**N_IN-1.

---
 rtl/fxywz_sweep_ctrl.sv | 145 ++++++++++++++
 tb/tb_fxywz_sweep_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fxywz_sweep_ctrl.sv
// rtl/fxywz_sweep_ctrl.sv - clocked, restartable truth-table sweep of the fxywz function block
// Optional self-check (exp_table/mismatch/err_cnt) is built only when SWEEP_CHECK_EN is defined.
module fxywz_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [N_OUT-1:0]            fn_out,
`ifdef SWEEP_CHECK_EN
  input  logic [N_OUT*(2**N_IN)-1:0]  exp_table,
  output logic                        mismatch,
  output logic [N_IN:0]               err_cnt,
`endif
  output logic [N_IN-1:0]             fn_in,
  output logic [N_IN-1:0]             idx,
  output logic                        busy,
  output logic                        done,
  output logic [N_OUT*(2**N_IN)-1:0]  table_out
);

  localparam int NV = 2**N_IN;
  localparam int TW = N_OUT * NV;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_RELOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST   = '1;

  if (SETTLE < 1) begin : g_bad_settle
    $error("fxywz_sweep_ctrl: SETTLE must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          state_q;
  logic [N_IN-1:0] idx_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [TW-1:0]   table_q;
  logic [TW-1:0]   table_d;
  logic [NV-1:0]   col_mask;

  // One-hot column select; each output bit k owns the NV-bit slice k*NV.
  assign col_mask = {{(NV-1){1'b0}}, 1'b1} << idx_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_col
    assign table_d[k*NV +: NV] = (table_q[k*NV +: NV] & ~col_mask)
                               | ({NV{fn_out[k]}} & col_mask);
  end

`ifdef SWEEP_CHECK_EN
  logic [N_IN:0]    err_q;
  logic [N_IN:0]    err_d;
  logic             mismatch_q;
  logic [N_OUT-1:0] col_diff;
  logic [N_IN+1:0]  err_sum;

  for (genvar k = 0; k < N_OUT; k++) begin : g_diff
    assign col_diff[k] = |(({NV{fn_out[k]}} ^ exp_table[k*NV +: NV]) & col_mask);
  end

  always_comb begin
    err_sum = {1'b0, err_q} + (N_IN+2)'($countones(col_diff));
    err_d   = err_sum[N_IN+1] ? '1 : err_sum[N_IN:0];
  end

  assign mismatch = mismatch_q;
  assign err_cnt  = err_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
`ifdef SWEEP_CHECK_EN
      err_q      <= '0;
      mismatch_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_q <= S_WAIT;
            idx_q   <= '0;
            cnt_q   <= CNT_RELOAD;
            busy_q  <= 1'b1;
            table_q <= '0;
`ifdef SWEEP_CHECK_EN
            err_q   <= '0;
`endif
          end
        end
        S_WAIT: begin
          // A settled column is captured even on the edge that aborts.
          if (cnt_q == '0) begin
            table_q <= table_d;
`ifdef SWEEP_CHECK_EN
            err_q   <= err_d;
`endif
          end
          if (abort) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (idx_q == IDX_LAST) begin
            state_q <= S_DONE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef SWEEP_CHECK_EN
            mismatch_q <= (err_d != '0);
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
            cnt_q <= CNT_RELOAD;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
`ifdef SWEEP_CHECK_EN
          mismatch_q <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fn_in     = idx_q;
  assign idx       = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;

endmodule

// File: tb/tb_fxywz_sweep_ctrl.sv
// tb/tb_fxywz_sweep_ctrl.sv - self-checking bench for fxywz_sweep_ctrl (SETTLE=1 and SETTLE=3 instances)
module tb_fxywz_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort;
  logic [3:0]  fn_in1, idx1, fn_in3, idx3;
  logic        busy1, done1, busy3, done3;
  logic [31:0] tab1, tab3;
  logic [1:0]  fo1, fo3;

  function automatic logic fx(input int m);
    return (m >= 8) && (m != 15);
  endfunction

  assign fo1 = {2{fx(int'(fn_in1))}};
  assign fo3 = {2{fx(int'(fn_in3))}};

`ifdef SWEEP_CHECK_EN
  logic [31:0] exp1, exp3;
  logic        mm1, mm3;
  logic [4:0]  ec1, ec3;
`endif

  fxywz_sweep_ctrl #(.N_IN(4), .N_OUT(2), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .fn_out(fo1),
`ifdef SWEEP_CHECK_EN
    .exp_table(exp1), .mismatch(mm1), .err_cnt(ec1),
`endif
    .fn_in(fn_in1), .idx(idx1), .busy(busy1), .done(done1), .table_out(tab1)
  );

  fxywz_sweep_ctrl #(.N_IN(4), .N_OUT(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .fn_out(fo3),
`ifdef SWEEP_CHECK_EN
    .exp_table(exp3), .mismatch(mm3), .err_cnt(ec3),
`endif
    .fn_in(fn_in3), .idx(idx3), .busy(busy3), .done(done3), .table_out(tab3)
  );

  // Reference: a sweep is "age" edges old; vector = age/SETTLE, captured on its last settle cycle.
  typedef struct {
    bit          act;
    int          age;
    bit          dn;
    logic [31:0] tbl;
    int          err;
  } model_t;

  model_t m1, m3;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ex1 = 32'h7F00_7F01;
  logic [31:0] ex3 = 32'h7F00_7F00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(inout model_t m, input int s, input logic [31:0] ex);
    int  v;
    bit  capt;
    if (!rst_n) begin
      m.act = 0; m.age = 0; m.dn = 0; m.tbl = '0; m.err = 0;
    end else if (m.dn) begin
      m.dn = 0;
    end else if (m.act) begin
      v    = m.age / s;
      capt = (m.age % s) == (s - 1);
      if (capt) begin
        for (int k = 0; k < 2; k++) begin
          m.tbl = m.tbl | (32'(fx(v)) << (k*16 + v));
          if (((ex >> (k*16 + v)) & 32'd1) != 32'(fx(v))) m.err++;
        end
      end
      if (abort) m.act = 0;
      else if (capt && v == 15) begin
        m.act = 0;
        m.dn  = 1;
      end
      m.age++;
    end else if (start && !abort) begin
      m.act = 1; m.age = 0; m.tbl = '0; m.err = 0;
    end
  endtask

  task automatic chk_inst(input string p, input model_t m, input int s, input logic b,
                          input logic d, input logic [3:0] fi, input logic [3:0] ix,
                          input logic [31:0] tb);
    logic [3:0] ei;
    ei = m.act ? 4'(m.age / s) : 4'd0;
    chk({p, "_busy"}, 32'(b), 32'(m.act));
    chk({p, "_done"}, 32'(d), 32'(m.dn));
    chk({p, "_fn_in"}, 32'(fi), 32'(ei));
    chk({p, "_idx"}, 32'(ix), 32'(ei));
    chk({p, "_table"}, tb, m.tbl);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(m1, 1, ex1);
    model_step(m3, 3, ex3);
    #1;
    chk_inst("s1", m1, 1, busy1, done1, fn_in1, idx1, tab1);
    chk_inst("s3", m3, 3, busy3, done3, fn_in3, idx3, tab3);
`ifdef SWEEP_CHECK_EN
    chk("s1_err_cnt", 32'(ec1), (m1.err > 31) ? 32'd31 : 32'(m1.err));
    chk("s3_err_cnt", 32'(ec3), (m3.err > 31) ? 32'd31 : 32'(m3.err));
    chk("s1_mismatch", 32'(mm1), 32'(m1.dn && m1.err != 0));
    chk("s3_mismatch", 32'(mm3), 32'(m3.dn && m3.err != 0));
`endif
  endtask

  initial begin
    int fd1, fd3, ndone;
`ifdef SWEEP_CHECK_EN
    exp1 = ex1;
    exp3 = ex3;
`endif
    m1 = '{0, 0, 0, '0, 0};
    m3 = '{0, 0, 0, '0, 0};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_fn_in", 32'(fn_in1), 32'd0);
    chk("rst_table", tab1, 32'h0);
    rst_n = 1'b1;
    tick();

    // Full sweep: latency counted with the accepting edge as edge 1.
    start = 1'b1; tick(); start = 1'b0;
    fd1 = 0; fd3 = 0;
    for (int e = 2; e <= 60; e++) begin
      tick();
      if (done1 && fd1 == 0) fd1 = e;
      if (done3 && fd3 == 0) fd3 = e;
    end
    chk("lat_settle1", 32'(fd1), 32'd17);
    chk("lat_settle3", 32'(fd3), 32'd49);
    chk("table_settle1", tab1, 32'h7F00_7F00);
    chk("table_settle3", tab3, 32'h7F00_7F00);

    // Start pulse while the SETTLE=1 sweep sits at m=5 is ignored.
    start = 1'b1; tick(); start = 1'b0;
    fd1 = 0;
    for (int e = 2; e <= 60; e++) begin
      start = (e == 7);
      tick();
      if (done1 && fd1 == 0) fd1 = e;
    end
    start = 1'b0;
    chk("lat_restart_ignored", 32'(fd1), 32'd17);

    // Abort while m=9 is on the bus.
    start = 1'b1; tick(); start = 1'b0;
    for (int e = 2; e <= 10; e++) tick();
    chk("abort_at_m9", 32'(fn_in1), 32'd9);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_table", tab1, 32'h0300_0300);
    ndone = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (done1 || done3) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // start and abort together: abort wins.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    tick();
    chk("start_abort_busy", 32'(busy1), 32'd0);

    // Reset mid-sweep.
    start = 1'b1; tick(); start = 1'b0;
    for (int e = 0; e < 12; e++) tick();
    rst_n = 1'b0; tick();
    chk("midrst_busy", 32'(busy3), 32'd0);
    chk("midrst_fn_in", 32'(fn_in1), 32'd0);
    chk("midrst_table", tab1, 32'h0);
    rst_n = 1'b1; tick();

    // Random start/abort/reset traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 40) == 0);
      rst_n = ($urandom_range(0, 250) != 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
